input_controller: RTL and testbench
===================================

INPUT_CONTROLLER -- requirements
Module: input_controller

Interface
REQ-001 Parameter CODE_LENGTH, 1024, LLR words per frame.
REQ-002 Parameter ADDR_WIDTH, 10, input-buffer BRAM address width; 2**ADDR_WIDTH >= CODE_LENGTH.
REQ-003 Parameter DATA_WIDTH, 8, LLR word width.
REQ-004 Parameter STATE_WIDTH, 8, width of top-level decoder state bus.
REQ-005 Parameter INPUT_STATE, 8'd1, top-level state code enabling frame reception.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 state  in  STATE_WIDTH  top-level decoder state.
REQ-010 saxis_tdata  in  DATA_WIDTH  AXI-Stream slave LLR data.
REQ-011 saxis_tvalid  in  1  slave beat valid.
REQ-012 saxis_tlast  in  1  last beat of frame.
REQ-013 saxis_tready  out  1  block accepts beat.
REQ-014 addr_to_input_buffer_bram  out  ADDR_WIDTH  BRAM write address.
REQ-015 data_to_input_buffer_bram  out  DATA_WIDTH  BRAM write data.
REQ-016 write_enable_to_input_buffer_bram  out  1  BRAM write strobe.
REQ-017 input_done  out  1  one-cycle pulse: full frame resident in BRAM.
REQ-018 frame_error  out  1  sticky tlast-mismatch flag for current frame.

Function
REQ-019 FSM states IDLE, RECEIVE, DRAIN, FLUSH, DONE; encoding in shared package.
REQ-020 IDLE -> RECEIVE when state==INPUT_STATE; beat counter (ADDR_WIDTH+1 bits) cleared on entry.
REQ-021 saxis_tready = 1 only in RECEIVE and DRAIN; combinational from FSM register, never from saxis_tvalid.
REQ-022 Accept = saxis_tvalid & saxis_tready; counter increments by 1 per accept in RECEIVE only.
REQ-023 Each RECEIVE accept registers write: next cycle write_enable=1, addr=counter value at accept, data=tdata at accept (latency 1); write_enable=0 otherwise.
REQ-024 Accept with counter==CODE_LENGTH-1 and tlast=1 -> FLUSH.
REQ-025 Accept with counter==CODE_LENGTH-1 and tlast=0 -> frame_error=1, DRAIN.
REQ-026 Accept with counter<CODE_LENGTH-1 and tlast=1 (short frame) -> beat written, frame_error=1, FLUSH.
REQ-027 DRAIN: beats accepted and discarded (no BRAM write) until accepted beat has tlast=1 -> FLUSH.
REQ-028 FLUSH: one cycle (final write completes) -> DONE; input_done=1 for exactly the first DONE cycle.
REQ-029 DONE held, tready=0, until state!=INPUT_STATE -> IDLE; frame_error cleared on IDLE entry.
REQ-030 state!=INPUT_STATE in RECEIVE/DRAIN/FLUSH -> IDLE next cycle; pending registered write suppressed; no input_done.
REQ-031 Counter never exceeds CODE_LENGTH; no address wrap-around.

Reset
REQ-032 reset=1 -> FSM IDLE, counter 0, saxis_tready 0, write_enable 0, addr 0, data 0, input_done 0, frame_error 0, next cycle.
REQ-033 reset mid-frame discards partial frame; no write or input_done follows reset release.

Structure
REQ-034 FSM state enum, INPUT_STATE and other top-level state codes in shared package polar_pkg.
REQ-035 Single flat module; no sub-modules.

Verification
REQ-036 1024 beats, tvalid always 1, tlast on beat 1023 -> 1024 writes addr 0..1023 data matching, input_done single pulse 2 cycles after last accept, frame_error 0.
REQ-037 Random tvalid gaps (50%) -> identical BRAM contents to REQ-036, write count 1024, tready never drops in RECEIVE.
REQ-038 tlast on beat 99 -> writes addr 0..99, frame_error 1, input_done pulse, no writes after.
REQ-039 No tlast on beat 1023, tlast on beat 1030 -> writes 0..1023 only, beats 1024..1030 accepted/discarded, frame_error 1, input_done after beat 1030.
REQ-040 state leaves INPUT_STATE after beat 500 -> IDLE, tready 0 next cycle, no input_done; reassert -> new frame writes from addr 0.
REQ-041 reset asserted after beat 300 -> all outputs at reset values next cycle, no write or input_done follows.

Source files
------------

// File: rtl/polar_pkg.sv
// Shared definitions for the polar decoder: top-level decoder state codes and
// the input controller FSM encoding.
package polar_pkg;

    localparam logic [7:0] ST_IDLE   = 8'd0;
    localparam logic [7:0] ST_INPUT  = 8'd1;
    localparam logic [7:0] ST_DECODE = 8'd2;
    localparam logic [7:0] ST_OUTPUT = 8'd3;

    typedef enum logic [2:0] {
        IC_IDLE,
        IC_RECEIVE,
        IC_DRAIN,
        IC_FLUSH,
        IC_DONE
    } ic_state_e;

endpackage

// File: rtl/input_controller.sv
// Accepts one LLR frame from an AXI-Stream slave and writes it into the input
// buffer BRAM, flagging frames whose tlast does not land on the final word.
module input_controller
    import polar_pkg::*;
#(
    parameter int                     CODE_LENGTH = 1024,
    parameter int                     ADDR_WIDTH  = 10,
    parameter int                     DATA_WIDTH  = 8,
    parameter int                     STATE_WIDTH = 8,
    parameter logic [STATE_WIDTH-1:0] INPUT_STATE = STATE_WIDTH'(ST_INPUT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STATE_WIDTH-1:0] state,
    input  logic [DATA_WIDTH-1:0]  saxis_tdata,
    input  logic                   saxis_tvalid,
    input  logic                   saxis_tlast,
    output logic                   saxis_tready,
    output logic [ADDR_WIDTH-1:0]  addr_to_input_buffer_bram,
    output logic [DATA_WIDTH-1:0]  data_to_input_buffer_bram,
    output logic                   write_enable_to_input_buffer_bram,
    output logic                   input_done,
    output logic                   frame_error
);

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(CODE_LENGTH - 1);

    ic_state_e                    fsm_q, fsm_d;
    logic [ADDR_WIDTH:0]          cnt_q;
    logic                         in_state, accept, rx_accept, last_beat, set_err;
    logic                         wr_vld_p1;
    logic [ADDR_WIDTH-1:0]        wr_addr_p1;
    logic signed [DATA_WIDTH-1:0] llr_p1;
    logic                         done_q, err_q;

    always_comb begin
        in_state     = (state == INPUT_STATE);
        saxis_tready = (fsm_q == IC_RECEIVE) || (fsm_q == IC_DRAIN);
        accept       = saxis_tvalid && saxis_tready;
        // a beat taken in the same cycle the decoder leaves INPUT_STATE is dropped
        rx_accept    = accept && (fsm_q == IC_RECEIVE) && in_state;
        last_beat    = (cnt_q == LAST_IDX);
        fsm_d        = fsm_q;
        set_err      = 1'b0;
        case (fsm_q)
            IC_IDLE: begin
                if (in_state) fsm_d = IC_RECEIVE;
            end
            IC_RECEIVE: begin
                if (!in_state) begin
                    fsm_d = IC_IDLE;
                end else if (accept) begin
                    if (last_beat) begin
                        fsm_d   = saxis_tlast ? IC_FLUSH : IC_DRAIN;
                        set_err = !saxis_tlast;
                    end else if (saxis_tlast) begin
                        fsm_d   = IC_FLUSH;
                        set_err = 1'b1;
                    end
                end
            end
            IC_DRAIN: begin
                if (!in_state)                  fsm_d = IC_IDLE;
                else if (accept && saxis_tlast) fsm_d = IC_FLUSH;
            end
            IC_FLUSH: begin
                fsm_d = in_state ? IC_DONE : IC_IDLE;
            end
            IC_DONE: begin
                if (!in_state) fsm_d = IC_IDLE;
            end
            default: fsm_d = IC_IDLE;
        endcase
    end

    // stage p1: registered BRAM write, one cycle after the accepting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q      <= IC_IDLE;
            cnt_q      <= '0;
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            llr_p1     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            wr_vld_p1 <= rx_accept;
            done_q    <= (fsm_q == IC_FLUSH) && (fsm_d == IC_DONE);
            if ((fsm_q == IC_IDLE) && (fsm_d == IC_RECEIVE))
                cnt_q <= '0;
            else if (rx_accept)
                cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
            if ((fsm_d == IC_IDLE) && (fsm_q != IC_IDLE))
                err_q <= 1'b0;
            else if (set_err)
                err_q <= 1'b1;
            if (rx_accept) begin
                wr_addr_p1 <= cnt_q[ADDR_WIDTH-1:0];
                llr_p1     <= saxis_tdata;
            end
        end
    end

    assign addr_to_input_buffer_bram         = wr_addr_p1;
    assign data_to_input_buffer_bram         = llr_p1;
    assign write_enable_to_input_buffer_bram = wr_vld_p1;
    assign input_done                        = done_q;
    assign frame_error                       = err_q;

endmodule

// File: tb/tb_input_controller.sv
// Self-checking bench for input_controller: frame scenarios from a vector table,
// random frames against a frame-level reference model, abort and reset sequences.
module tb_input_controller;

    localparam int         CL   = 1024;
    localparam logic [7:0] INST = 8'd1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] state = 8'd0;
    logic [7:0] saxis_tdata = 8'd0;
    logic       saxis_tvalid = 1'b0;
    logic       saxis_tlast = 1'b0;
    logic       saxis_tready;
    logic [9:0] addr_to_input_buffer_bram;
    logic [7:0] data_to_input_buffer_bram;
    logic       write_enable_to_input_buffer_bram;
    logic       input_done;
    logic       frame_error;

    input_controller dut (
        .clk                               (clk),
        .reset                             (reset),
        .state                             (state),
        .saxis_tdata                       (saxis_tdata),
        .saxis_tvalid                      (saxis_tvalid),
        .saxis_tlast                       (saxis_tlast),
        .saxis_tready                      (saxis_tready),
        .addr_to_input_buffer_bram         (addr_to_input_buffer_bram),
        .data_to_input_buffer_bram         (data_to_input_buffer_bram),
        .write_enable_to_input_buffer_bram (write_enable_to_input_buffer_bram),
        .input_done                        (input_done),
        .frame_error                       (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int last_idx;
        int gap_pct;
        int exp_writes;
        bit exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int wa[$];
    int wd[$];
    int done_cnt;
    int done_cyc;
    bit err_at_done;
    logic [7:0] d [0:1100];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // write/done monitor, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (write_enable_to_input_buffer_bram) begin
            wa.push_back(int'(addr_to_input_buffer_bram));
            wd.push_back(int'(data_to_input_buffer_bram));
        end
        if (input_done) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = frame_error;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int count_bad(input int n);
        int bad = 0;
        for (int j = 0; j < n; j++)
            if (j >= wa.size() || wa[j] != j || wd[j] != int'(d[j])) bad++;
        return bad;
    endfunction

    function automatic int model_writes(input int last_idx);
        return (last_idx < CL - 1) ? last_idx + 1 : CL;
    endfunction

    task automatic clear_frame(input int nbeats);
        wa.delete();
        wd.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        err_at_done = 1'b0;
        for (int k = 0; k < nbeats; k++) d[k] = 8'($urandom);
    endtask

    task automatic start_frame(input string nm);
        int n = 0;
        state = INST;
        @(posedge clk); #1;
        while (!saxis_tready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_tready_rise"}, saxis_tready, 1);
    endtask

    // drives beats 0..upto; returns the cycle of the final accept and any tready drops
    task automatic send_beats(input int upto, input int tlast_idx, input int gap_pct,
                              output int acc_cyc, output int drops);
        int k = 0;
        int guard = 0;
        drops   = 0;
        acc_cyc = -1;
        while (k <= upto && guard < 5000) begin
            guard++;
            if (!saxis_tready) drops++;
            saxis_tvalid = ($urandom_range(0, 99) >= gap_pct);
            saxis_tdata  = d[k];
            saxis_tlast  = (k == tlast_idx);
            if (saxis_tvalid && saxis_tready) begin
                acc_cyc = cyc;
                k++;
            end
            @(posedge clk); #1;
        end
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        if (k <= upto) check("send_timeout", k, upto + 1);
    endtask

    task automatic run_frame(input string nm, input int last_idx, input int gap_pct,
                             input int exp_w, input bit exp_err);
        int acc_cyc, drops;
        clear_frame(last_idx + 1);
        start_frame(nm);
        send_beats(last_idx, last_idx, gap_pct, acc_cyc, drops);
        repeat (4) @(posedge clk);
        #1;
        check({nm, "_writes"},     wa.size(), exp_w);
        check({nm, "_content"},    count_bad(exp_w), 0);
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_done_time"},  done_cyc, acc_cyc + 2);
        check({nm, "_frame_err"},  err_at_done, exp_err);
        check({nm, "_ready_drop"}, drops, 0);
        check({nm, "_ready_done"}, saxis_tready, 0);
        state = 8'd0;
        @(posedge clk); #1;
        check({nm, "_err_clear"},  frame_error, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[7];
        int acc_cyc, drops, li;
        vecs[0] = '{1023,  0, 1024, 1'b0};
        vecs[1] = '{1023, 50, 1024, 1'b0};
        vecs[2] = '{  99,  0,  100, 1'b1};
        vecs[3] = '{1030,  0, 1024, 1'b1};
        vecs[4] = '{   0,  0,    1, 1'b1};
        vecs[5] = '{1022, 25, 1023, 1'b1};
        vecs[6] = '{1024, 40, 1024, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", saxis_tready, 0);
        check("rst_we",     write_enable_to_input_buffer_bram, 0);
        check("rst_addr",   addr_to_input_buffer_bram, 0);
        check("rst_data",   data_to_input_buffer_bram, 0);
        check("rst_done",   input_done, 0);
        check("rst_err",    frame_error, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_tready", saxis_tready, 0);

        for (int r = 0; r < 7; r++)
            run_frame($sformatf("vec%0d", r), vecs[r].last_idx, vecs[r].gap_pct,
                      vecs[r].exp_writes, vecs[r].exp_err);

        for (int r = 0; r < 4; r++) begin
            case ($urandom_range(0, 2))
                0:       li = $urandom_range(0, CL - 2);
                1:       li = CL - 1;
                default: li = $urandom_range(CL, CL + 16);
            endcase
            run_frame($sformatf("rnd%0d", r), li, $urandom_range(0, 60),
                      model_writes(li), li != CL - 1);
        end

        // decoder leaves INPUT_STATE mid-frame
        clear_frame(501);
        start_frame("abort");
        send_beats(500, -1, 0, acc_cyc, drops);
        @(posedge clk); #1;
        state = 8'd0;
        @(posedge clk); #1;
        check("abort_tready", saxis_tready, 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_writes",  wa.size(), 501);
        check("abort_content", count_bad(501), 0);
        check("abort_done",    done_cnt, 0);
        check("abort_err",     frame_error, 0);
        run_frame("reframe", CL - 1, 10, CL, 1'b0);

        // reset mid-frame
        clear_frame(302);
        start_frame("rstmid");
        send_beats(300, -1, 0, acc_cyc, drops);
        reset        = 1'b1;
        saxis_tvalid = 1'b1;
        saxis_tdata  = d[301];
        @(posedge clk); #1;
        check("rstmid_tready", saxis_tready, 0);
        check("rstmid_we",     write_enable_to_input_buffer_bram, 0);
        check("rstmid_addr",   addr_to_input_buffer_bram, 0);
        check("rstmid_data",   data_to_input_buffer_bram, 0);
        check("rstmid_done",   input_done, 0);
        check("rstmid_err",    frame_error, 0);
        reset        = 1'b0;
        saxis_tvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rstmid_writes",  wa.size(), 301);
        check("rstmid_content", count_bad(301), 0);
        check("rstmid_nodone",  done_cnt, 0);
        state = 8'd0;
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
